// File: rtl/dmem_responder_way0.sv
// rtl/dmem_responder_way0.sv - way0 load/store responder modelling a single-ported 64-bit data memory
// One request in flight; DONE doubles as an accept slot so back-to-back requests have no gap.
module dmem_responder_way0 #(
   parameter int          DEPTH_WORDS   = 1024,
   parameter logic [31:0] BASE_ADDR     = 32'h8000_0000,
   parameter int          READ_LATENCY  = 2,
   parameter int          WRITE_LATENCY = 2
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        valid_i,
   input  logic [31:0] readAddr_i,
   input  logic [31:0] writeAddr_i,
   input  logic [63:0] writeData_i,
   input  logic [3:0]  writeMask_i,
   output logic [63:0] readData_o,
   output logic        dataOk_o,
   output logic [2:0]  writeState_o,
   output logic        accessErr_o,
   output logic        busy_o
);

   localparam int         IDX_W  = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
   localparam logic [3:0] RD_LAT = 4'(READ_LATENCY);
   localparam logic [3:0] WR_LAT = 4'(WRITE_LATENCY);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_RD_BUSY,
      ST_WR_BUSY,
      ST_DONE
   } state_t;

   state_t             state_q, state_d;
   logic [3:0]         cnt_q, cnt_d;
   logic               is_rd_q, is_rd_d;
   logic               err_q, err_d;
   logic [IDX_W-1:0]   idx_q, idx_d;
   logic [63:0]        wdata_q, wdata_d;
   logic [3:0]         wmask_q, wmask_d;
   logic [63:0]        rdata_q, rdata_d;

   logic [63:0]        mem [DEPTH_WORDS];

   logic               rd_req, wr_req, accept, commit, sel_ok;
   logic [31:0]        sel_addr, word_off;
   logic [3:0]         lat;

   // The read address wins when both are nonzero; the write is simply dropped.
   assign rd_req   = |readAddr_i;
   assign wr_req   = |writeAddr_i;
   assign accept   = valid_i && (rd_req || wr_req) &&
                     ((state_q == ST_IDLE) || (state_q == ST_DONE));
   assign sel_addr = rd_req ? readAddr_i : writeAddr_i;
   assign word_off = (sel_addr - BASE_ADDR) >> 3;
   assign sel_ok   = (sel_addr >= BASE_ADDR) && (word_off < 32'(DEPTH_WORDS));
   assign lat      = rd_req ? RD_LAT : WR_LAT;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      is_rd_d = is_rd_q;
      err_d   = err_q;
      idx_d   = idx_q;
      wdata_d = wdata_q;
      wmask_d = wmask_q;
      case (state_q)
         ST_IDLE, ST_DONE: begin
            state_d = ST_IDLE;
            if (accept) begin
               is_rd_d = rd_req;
               err_d   = !sel_ok;
               idx_d   = word_off[IDX_W-1:0];
               wdata_d = writeData_i;
               wmask_d = writeMask_i;
               cnt_d   = lat - 4'd1;
               if (lat <= 4'd1) begin
                  state_d = ST_DONE;
               end else begin
                  state_d = rd_req ? ST_RD_BUSY : ST_WR_BUSY;
               end
            end
         end
         ST_RD_BUSY, ST_WR_BUSY: begin
            // DONE must land exactly LATENCY cycles after acceptance.
            if (cnt_q <= 4'd1) begin
               cnt_d   = 4'd0;
               state_d = ST_DONE;
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Entering DONE is the single point where the array is written or sampled.
   assign commit = (state_d == ST_DONE);

   always_comb begin
      rdata_d = rdata_q;
      if (commit && is_rd_d) begin
         rdata_d = err_d ? 64'd0 : mem[idx_d];
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= ST_IDLE;
         cnt_q   <= 4'd0;
         is_rd_q <= 1'b0;
         err_q   <= 1'b0;
         idx_q   <= '0;
         wdata_q <= 64'd0;
         wmask_q <= 4'd0;
         rdata_q <= 64'd0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         is_rd_q <= is_rd_d;
         err_q   <= err_d;
         idx_q   <= idx_d;
         wdata_q <= wdata_d;
         wmask_q <= wmask_d;
         rdata_q <= rdata_d;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset && commit && !is_rd_d && !err_d) begin
         for (int k = 0; k < 4; k++) begin
            if (wmask_d[k]) begin
               mem[idx_d][16*k +: 16] <= wdata_d[16*k +: 16];
            end
         end
      end
   end

   assign readData_o   = rdata_q;
   assign dataOk_o     = (state_q == ST_DONE) && is_rd_q;
   assign accessErr_o  = (state_q == ST_DONE) && err_q;
   assign busy_o       = (state_q == ST_RD_BUSY) || (state_q == ST_WR_BUSY);
   assign writeState_o = (state_q == ST_WR_BUSY)             ? 3'b001 :
                         ((state_q == ST_DONE) && !is_rd_q)  ? 3'b111 : 3'b000;

endmodule
